// File: rtl/spine_port_pkg.sv
// Shared definitions for the spine-side leaf port.
//   DEST_W          width of the destination field carried inside each flit
//   ptr_width()     FIFO pointer width (address bits plus one wrap bit)
//   ingress_state_e ingress FSM states
//   dest_field()    extracts the destination field whose MSB sits at a given bit
package spine_port_pkg;

  localparam int unsigned DEST_W = 6;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } ingress_state_e;

  // One extra bit lets full and empty be told apart when the address bits match.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // The flit is zero-extended to 64 bits by the caller, so DWIDTH may be up to 64.
  function automatic logic [DEST_W-1:0] dest_field(input logic [63:0] flit,
                                                   input int unsigned msb);
    return DEST_W'(flit >> (msb - DEST_W + 1));
  endfunction

endpackage

// File: rtl/spine_port_fifo.sv
// Show-ahead synchronous FIFO used for the egress path.
// The head entry is visible on rd_data whenever empty is low, straight out of the storage
// flops, so a write into an empty FIFO is readable on the following cycle.
// A write into a full FIFO succeeds only if the head is popped in the same cycle;
// otherwise it is rejected and drop pulses for that cycle.
// Ports:
//   clk, reset       clock, asynchronous active-high reset (clears pointers and storage)
//   wr_valid/wr_data write request and data
//   rd_ready         pop the head when the FIFO is not empty
//   rd_data          head entry
//   empty            no entries stored
//   drop             write rejected because the FIFO was full and not popping
module spine_port_fifo
  import spine_port_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = ~empty & rd_ready;
  // When full, the slot being written is the head that is leaving this same cycle.
  assign push  = wr_valid & (~full | pop);
  assign drop  = wr_valid & full & ~pop;

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/spine_leaf_port.sv
// Spine-side endpoint of one leaf-router spine link.
// Egress: the router's valid-only spine output is buffered in a show-ahead FIFO and offered
// to the fabric with valid/ready. Flits arriving while the FIFO is full (and not popping)
// are dropped and counted.
// Ingress: fabric flits are accepted one at a time and driven to the router as a one-cycle
// valid pulse followed by MIN_GAP idle cycles, since the router cannot backpressure.
// Optional build macro SPINE_PORT_PARITY_EN adds even parity: fab_tx_parity on egress,
// fab_rx_parity on ingress, and par_err_sticky. Ingress flits with bad parity are accepted
// but not forwarded.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   rtr_out_data/valid              router spine output stream (no ready)
//   rtr_in_data/valid, rtr_dest_addr router spine input triple
//   fab_tx_data/valid/ready         egress fabric handshake
//   fab_rx_data/valid/ready         ingress fabric handshake
//   ovf_sticky, ovf_count           egress overflow flag and saturating drop count
module spine_leaf_port
  import spine_port_pkg::*;
#(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MIN_GAP    = 1,
  parameter int unsigned ADDR_MSB   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] rtr_out_data,
  input  logic              rtr_out_valid,
  output logic [DWIDTH-1:0] rtr_in_data,
  output logic              rtr_in_valid,
  output logic [DEST_W-1:0] rtr_dest_addr,
  output logic [DWIDTH-1:0] fab_tx_data,
  output logic              fab_tx_valid,
  input  logic              fab_tx_ready,
  input  logic [DWIDTH-1:0] fab_rx_data,
  input  logic              fab_rx_valid,
  output logic              fab_rx_ready,
`ifdef SPINE_PORT_PARITY_EN
  output logic              fab_tx_parity,
  input  logic              fab_rx_parity,
  output logic              par_err_sticky,
`endif
  output logic              ovf_sticky,
  output logic [7:0]        ovf_count
);

  // ---------------------------------------------------------------------------
  // Egress
  // ---------------------------------------------------------------------------
`ifdef SPINE_PORT_PARITY_EN
  localparam int unsigned EW = DWIDTH + 1;
`else
  localparam int unsigned EW = DWIDTH;
`endif

  logic [EW-1:0] fifo_wdata, fifo_rdata;
  logic          fifo_empty, fifo_drop;
  logic          ovf_sticky_q;
  logic [7:0]    ovf_count_q;

`ifdef SPINE_PORT_PARITY_EN
  assign fifo_wdata    = {^rtr_out_data, rtr_out_data};
  assign fab_tx_data   = fifo_rdata[DWIDTH-1:0];
  assign fab_tx_parity = fifo_rdata[DWIDTH];
`else
  assign fifo_wdata    = rtr_out_data;
  assign fab_tx_data   = fifo_rdata;
`endif

  spine_port_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_egress_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (rtr_out_valid),
    .wr_data  (fifo_wdata),
    .rd_ready (fab_tx_ready),
    .rd_data  (fifo_rdata),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  assign fab_tx_valid = ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else if (fifo_drop) begin
      ovf_sticky_q <= 1'b1;
      if (ovf_count_q != 8'hFF) begin
        ovf_count_q <= ovf_count_q + 8'd1;
      end
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;

  // ---------------------------------------------------------------------------
  // Ingress
  // ---------------------------------------------------------------------------
  ingress_state_e    state_q, state_d;
  logic [DWIDTH-1:0] cap_q, cap_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  // Holds fab_rx_ready low until the first edge after reset is released.
  logic              run_q;
  logic              rx_fire;
  logic              rx_par_ok;

`ifdef SPINE_PORT_PARITY_EN
  logic par_err_q;
  assign rx_par_ok      = (fab_rx_parity == ^fab_rx_data);
  assign par_err_sticky = par_err_q;
`else
  assign rx_par_ok      = 1'b1;
`endif

  assign rx_fire = fab_rx_valid & fab_rx_ready;

  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    gap_cnt_d    = gap_cnt_q;
    fab_rx_ready = 1'b0;
    rtr_in_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        fab_rx_ready = run_q;
        // A flit failing parity completes its handshake but is not forwarded.
        if (rx_fire && rx_par_ok) begin
          cap_d   = fab_rx_data;
          state_d = StSend;
        end
      end
      StSend: begin
        rtr_in_valid = 1'b1;
        gap_cnt_d    = '0;
        state_d      = (MIN_GAP > 0) ? StGap : StIdle;
      end
      StGap: begin
        if (gap_cnt_q == 4'(MIN_GAP - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cap_q     <= '0;
      gap_cnt_q <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      gap_cnt_q <= gap_cnt_d;
      run_q     <= 1'b1;
    end
  end

`ifdef SPINE_PORT_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else if (rx_fire && !rx_par_ok) begin
      par_err_q <= 1'b1;
    end
  end
`endif

  // Data and destination hold the last forwarded flit between pulses.
  assign rtr_in_data   = cap_q;
  assign rtr_dest_addr = dest_field(64'(cap_q), ADDR_MSB);

endmodule

// File: tb/tb_spine_leaf_port.sv
// Self-checking bench for spine_leaf_port (DWIDTH=16, FIFO_DEPTH=8, MIN_GAP=1, ADDR_MSB=15).
// A negedge monitor keeps an occupancy/drop model of the egress FIFO and a scoreboard of
// expected egress and ingress flits; directed sequences exercise overflow, full-with-pop,
// ingress pacing, mid-operation reset and (when built with it) parity.
module tb_spine_leaf_port;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] rtr_out_data;
  logic          rtr_out_valid;
  logic [DW-1:0] rtr_in_data;
  logic          rtr_in_valid;
  logic [5:0]    rtr_dest_addr;
  logic [DW-1:0] fab_tx_data;
  logic          fab_tx_valid;
  logic          fab_tx_ready;
  logic [DW-1:0] fab_rx_data;
  logic          fab_rx_valid;
  logic          fab_rx_ready;
  logic          ovf_sticky;
  logic [7:0]    ovf_count;
`ifdef SPINE_PORT_PARITY_EN
  logic          fab_tx_parity;
  logic          fab_rx_parity;
  logic          par_err_sticky;
`endif

  spine_leaf_port #(
    .DWIDTH     (DW),
    .FIFO_DEPTH (DEPTH),
    .MIN_GAP    (GAP),
    .ADDR_MSB   (15)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rtr_out_data   (rtr_out_data),
    .rtr_out_valid  (rtr_out_valid),
    .rtr_in_data    (rtr_in_data),
    .rtr_in_valid   (rtr_in_valid),
    .rtr_dest_addr  (rtr_dest_addr),
    .fab_tx_data    (fab_tx_data),
    .fab_tx_valid   (fab_tx_valid),
    .fab_tx_ready   (fab_tx_ready),
    .fab_rx_data    (fab_rx_data),
    .fab_rx_valid   (fab_rx_valid),
    .fab_rx_ready   (fab_rx_ready),
`ifdef SPINE_PORT_PARITY_EN
    .fab_tx_parity  (fab_tx_parity),
    .fab_rx_parity  (fab_rx_parity),
    .par_err_sticky (par_err_sticky),
`endif
    .ovf_sticky     (ovf_sticky),
    .ovf_count      (ovf_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Scoreboard and models
  logic [DW-1:0] exp_eg[$];
  logic [DW-1:0] exp_rx[$];
  int            exp_rx_cyc[$];
  int            pulse_cyc[$];
  logic [5:0]    pulse_dest[$];
  int            occ_m       = 0;
  int            drop_m      = 0;
  int            busy_until  = -1;
  int            cyc         = 0;
  bit            mon_en      = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_eg.delete();
        exp_rx.delete();
        exp_rx_cyc.delete();
        occ_m      = 0;
        drop_m     = 0;
        busy_until = -1;
      end else if (mon_en) begin
        bit pop_m;
        bit push_m;
        bit par_ok;
        // Egress
        check("tx_valid", 32'(fab_tx_valid), 32'(occ_m != 0));
        check("ovf_count", 32'(ovf_count), 32'(drop_m));
        check("ovf_sticky", 32'(ovf_sticky), 32'(drop_m != 0));
        pop_m = (occ_m != 0) && fab_tx_ready;
        if (pop_m) begin
          check("eg_sb_nonempty", 32'(exp_eg.size() > 0), 32'd1);
          if (exp_eg.size() > 0) begin
            logic [DW-1:0] e;
            e = exp_eg.pop_front();
            check("tx_data", 32'(fab_tx_data), 32'(e));
`ifdef SPINE_PORT_PARITY_EN
            check("tx_parity", 32'(fab_tx_parity), 32'(^e));
`endif
          end
        end
        push_m = 1'b0;
        if (rtr_out_valid) begin
          if (occ_m < DEPTH || pop_m) begin
            exp_eg.push_back(rtr_out_data);
            push_m = 1'b1;
          end else if (drop_m < 255) begin
            drop_m++;
          end
        end
        occ_m = occ_m + int'(push_m) - int'(pop_m);
        // Ingress
        check("rx_ready", 32'(fab_rx_ready), 32'(cyc > busy_until));
        if (rtr_in_valid) begin
          check("rx_sb_nonempty", 32'(exp_rx.size() > 0), 32'd1);
          if (exp_rx.size() > 0) begin
            logic [DW-1:0] e;
            int            c;
            e = exp_rx.pop_front();
            c = exp_rx_cyc.pop_front();
            check("rtr_in_data", 32'(rtr_in_data), 32'(e));
            check("rtr_dest", 32'(rtr_dest_addr), 32'(e[15:10]));
            check("rtr_in_cycle", 32'(cyc), 32'(c));
          end
          pulse_cyc.push_back(cyc);
          pulse_dest.push_back(rtr_dest_addr);
        end
        par_ok = 1'b1;
`ifdef SPINE_PORT_PARITY_EN
        par_ok = (fab_rx_parity == ^fab_rx_data);
`endif
        if (fab_rx_valid && fab_rx_ready && par_ok) begin
          exp_rx.push_back(fab_rx_data);
          exp_rx_cyc.push_back(cyc + 1);
          busy_until = cyc + 1 + int'(GAP);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic eg_write(input logic [DW-1:0] d);
    rtr_out_valid = 1'b1;
    rtr_out_data  = d;
    step();
    rtr_out_valid = 1'b0;
  endtask

  // Offers one ingress flit and returns #1 after the edge that accepts it.
  task automatic rx_send(input logic [DW-1:0] d, input bit good_par);
    bit done;
    fab_rx_valid = 1'b1;
    fab_rx_data  = d;
`ifdef SPINE_PORT_PARITY_EN
    fab_rx_parity = good_par ? ^d : ~(^d);
`else
    if (!good_par) $display("note: parity ignored in this build");
`endif
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = fab_rx_ready;
    end
    check("rx_handshake", 32'(done), 32'd1);
    step();
    fab_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    mon_en = 1'b1;
  endtask

  initial begin
    reset         = 1'b1;
    rtr_out_data  = '0;
    rtr_out_valid = 1'b0;
    fab_tx_ready  = 1'b0;
    fab_rx_data   = '0;
    fab_rx_valid  = 1'b0;
`ifdef SPINE_PORT_PARITY_EN
    fab_rx_parity = 1'b0;
`endif
    #12;
    check("rst_rtr_in_valid", 32'(rtr_in_valid), 32'd0);
    check("rst_rtr_in_data", 32'(rtr_in_data), 32'd0);
    check("rst_dest", 32'(rtr_dest_addr), 32'd0);
    check("rst_tx_valid", 32'(fab_tx_valid), 32'd0);
    check("rst_tx_data", 32'(fab_tx_data), 32'd0);
    check("rst_rx_ready", 32'(fab_rx_ready), 32'd0);
    check("rst_ovf", 32'({ovf_sticky, ovf_count}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    mon_en = 1'b1;

    // Single flit, latency one
    fab_tx_ready = 1'b1;
    eg_write(16'hA5C3);
    check("lat1_valid", 32'(fab_tx_valid), 32'd1);
    check("lat1_data", 32'(fab_tx_data), 32'hA5C3);
    step();
    check("lat1_one_cycle", 32'(fab_tx_valid), 32'd0);

    // Overflow: 10 flits into 8 entries
    fab_tx_ready = 1'b0;
    for (int i = 1; i <= 10; i++) eg_write(DW'(i));
    check("ovf_count_2", 32'(ovf_count), 32'd2);
    check("ovf_sticky_1", 32'(ovf_sticky), 32'd1);
    check("tx_hold_head", 32'(fab_tx_data), 32'd1);
    fab_tx_ready = 1'b1;
    repeat (10) step();

    // Full with simultaneous pop: no drop
    fab_tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) eg_write(DW'(16'h0011 + i));
    fab_tx_ready = 1'b1;
    eg_write(16'h0019);
    repeat (10) step();
    check("full_pop_no_drop", 32'(ovf_count), 32'd2);

    // Ingress pacing with concurrent egress traffic
    pulse_cyc.delete();
    pulse_dest.delete();
    fork
      begin
        rx_send(16'hFC00, 1'b1);
        rx_send(16'h0400, 1'b1);
      end
      begin
        for (int i = 0; i < 8; i++) eg_write(DW'(16'h2000 + i));
      end
    join
    repeat (6) step();
    check("pulse_count", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) begin
      check("pulse_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(2 + GAP));
      check("dest_first", 32'(pulse_dest[0]), 32'h3F);
      check("dest_second", 32'(pulse_dest[1]), 32'h01);
    end
    check("rtr_data_hold", 32'(rtr_in_data), 32'h0400);

    // Reset during GAP with four flits buffered
    fab_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) eg_write(DW'(16'h3000 + i));
    rx_send(16'h1234, 1'b1);
    step();
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("mid_rst_tx_valid", 32'(fab_tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(fab_tx_data), 32'd0);
    check("mid_rst_rtr_valid", 32'(rtr_in_valid), 32'd0);
    check("mid_rst_rtr_data", 32'(rtr_in_data), 32'd0);
    check("mid_rst_rx_ready", 32'(fab_rx_ready), 32'd0);
    check("mid_rst_ovf", 32'({ovf_sticky, ovf_count}), 32'd0);
    step();
    reset = 1'b0;
    step();
    mon_en       = 1'b1;
    fab_tx_ready = 1'b1;
    repeat (12) step();

`ifdef SPINE_PORT_PARITY_EN
    check("par_err_clear", 32'(par_err_sticky), 32'd0);
    pulse_cyc.delete();
    rx_send(16'h0001, 1'b0);
    repeat (5) step();
    check("par_err_set", 32'(par_err_sticky), 32'd1);
    check("par_no_forward", 32'(pulse_cyc.size()), 32'd0);
    rx_send(16'h0003, 1'b1);
    repeat (4) step();
    check("par_good_forward", 32'(pulse_cyc.size()), 32'd1);
`endif

    do_reset();
    repeat (3) step();
    check("eg_sb_empty", 32'(exp_eg.size()), 32'd0);
    check("rx_sb_empty", 32'(exp_rx.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
